// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm
//   Services a cache miss by fetching one block from main memory and writing it
//   word by word into the cache data array, then pulsing the tag write. fsm_busy
//   stalls the pipeline until the block is resident. Read requests go out one per
//   cycle; returned words are counted, so the memory latency does not matter here.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for a miss; outputs quiet, memory returns ignored
//   FILL  | issuing BLOCK_WORDS reads and writing back returned words
//   DONE  | one-cycle tag/valid write, then back to IDLE
//
// Ports
//   clk, rst_n          clock / asynchronous active-low reset
//   miss_detected       cache miss level for miss_address
//   miss_address        byte address that missed
//   memory_data_valid   main memory returns a word this cycle
//   memory_data         returned word
//   fsm_busy            fill in progress (FILL or DONE)
//   mem_req_valid       read request issued this cycle
//   memory_address      byte address of the read being issued
//   fill_we             write fill_data at fill_word in the data array
//   fill_word           word index within the block
//   fill_data           word to write (memory_data)
//   tag_we              one-cycle tag/valid write pulse
module cache_fill_fsm #(
  parameter int BLOCK_WORDS = 8,
  parameter int ADDR_W      = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           miss_detected,
  input  logic [ADDR_W-1:0]              miss_address,
  input  logic                           memory_data_valid,
  input  logic [15:0]                    memory_data,
  output logic                           fsm_busy,
  output logic                           mem_req_valid,
  output logic [ADDR_W-1:0]              memory_address,
  output logic                           fill_we,
  output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
  output logic [15:0]                    fill_data,
  output logic                           tag_we
);

  localparam int CW  = $clog2(BLOCK_WORDS);
  // Byte offset bits inside a block of 16-bit words.
  localparam int OFF = CW + 1;
  localparam logic [CW:0] BW_CNT = (CW+1)'(BLOCK_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_nxt;
  // One extra bit so the counters can hold BLOCK_WORDS itself.
  logic [CW:0]       issue_cnt, issue_cnt_nxt;
  logic [CW:0]       recv_cnt, recv_cnt_nxt;
  logic [ADDR_W-1:0] base, base_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      base      <= '0;
    end else begin
      state     <= state_nxt;
      issue_cnt <= issue_cnt_nxt;
      recv_cnt  <= recv_cnt_nxt;
      base      <= base_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    issue_cnt_nxt  = issue_cnt;
    recv_cnt_nxt   = recv_cnt;
    base_nxt       = base;
    fsm_busy       = 1'b0;
    mem_req_valid  = 1'b0;
    memory_address = '0;
    fill_we        = 1'b0;
    fill_word      = '0;
    fill_data      = '0;
    tag_we         = 1'b0;

    case (state)
      IDLE: begin
        if (miss_detected) begin
          base_nxt           = miss_address;
          base_nxt[OFF-1:0]  = '0;
          issue_cnt_nxt      = '0;
          recv_cnt_nxt       = '0;
          state_nxt          = FILL;
        end
      end

      FILL: begin
        fsm_busy = 1'b1;
        if (issue_cnt < BW_CNT) begin
          mem_req_valid  = 1'b1;
          // base is block-aligned, so this add never carries out of the block.
          memory_address = base + ADDR_W'({issue_cnt, 1'b0});
          issue_cnt_nxt  = issue_cnt + 1'b1;
        end
        if (memory_data_valid && (recv_cnt < BW_CNT)) begin
          fill_we      = 1'b1;
          fill_word    = recv_cnt[CW-1:0];
          fill_data    = memory_data;
          recv_cnt_nxt = recv_cnt + 1'b1;
          if (recv_cnt == BW_CNT - 1'b1)
            state_nxt = DONE;
        end
      end

      DONE: begin
        fsm_busy  = 1'b1;
        tag_we    = 1'b1;
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule
